// File: rtl/inst_fetch.sv
// Instruction-fetch stage: single-beat req/ack read of imem, output register held until decode takes it.
// Optional IFETCH_TIMEOUT_EN build macro abandons a memory read after TIMEOUT_CYCLES wait cycles.
module inst_fetch #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] NOP_WORD       = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] pc_in,
   input  logic        pc_valid,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        id_ready,
   output logic        instr_valid,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   output logic        fetch_fault,
   output logic        pc_hold
);

   typedef enum logic [1:0] {IDLE, WAIT, VALID} state_t;

   state_t      state_q;
   logic [31:0] addr_q;
   logic [31:0] instr_q;
   logic        fault_q;
   logic        kill_q;

   logic        accept;
   logic        misaligned;
   logic        kill_now;
   logic        timed_out;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("inst_fetch: TIMEOUT_CYCLES must be in 1..255");
   end

   // A new target is taken only when the PC is not held and no flush is killing it.
   assign accept     = pc_valid & ~flush &
                       ((state_q == IDLE) | ((state_q == VALID) & id_ready));
   assign misaligned = (pc_in[1:0] != 2'b00);
   assign kill_now   = kill_q | flush;

`ifdef IFETCH_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] tmo_cnt_q;

   assign timed_out = (state_q == WAIT) & ~imem_ack & (tmo_cnt_q == TMO_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         tmo_cnt_q <= '0;
      else if (accept)
         tmo_cnt_q <= '0;
      else if ((state_q == WAIT) && !imem_ack)
         tmo_cnt_q <= tmo_cnt_q + 8'd1;
   end
`else
   assign timed_out = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         instr_q <= NOP_WORD;
         fault_q <= 1'b0;
         kill_q  <= 1'b0;
      end else if (accept) begin
         addr_q <= pc_in;
         kill_q <= 1'b0;
         if (misaligned) begin
            instr_q <= NOP_WORD;
            fault_q <= 1'b1;
            state_q <= VALID;
         end else begin
            state_q <= WAIT;
         end
      end else begin
         case (state_q)
            WAIT: begin
               // The request is never withdrawn on flush; the word is dropped on arrival.
               if (imem_ack) begin
                  kill_q <= 1'b0;
                  if (kill_now) begin
                     state_q <= IDLE;
                  end else begin
                     instr_q <= imem_rdata;
                     fault_q <= 1'b0;
                     state_q <= VALID;
                  end
               end else if (timed_out) begin
                  kill_q <= 1'b0;
                  if (kill_now) begin
                     state_q <= IDLE;
                  end else begin
                     instr_q <= NOP_WORD;
                     fault_q <= 1'b1;
                     state_q <= VALID;
                  end
               end else if (flush) begin
                  kill_q <= 1'b1;
               end
            end
            VALID: begin
               if (flush || id_ready)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign imem_req    = (state_q == WAIT);
   assign imem_addr   = addr_q;
   assign instr_valid = (state_q == VALID);
   assign instr_out   = instr_q;
   assign instr_pc    = addr_q;
   assign fetch_fault = fault_q;
   assign pc_hold     = (state_q == WAIT) | ((state_q == VALID) & ~id_ready);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: stimulus pushes expected retirements, a monitor pops them on handshake.
module tb_inst_fetch;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc_in = '0;
   logic        pc_valid = 1'b0;
   logic        flush = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        id_ready = 1'b1;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic        fetch_fault;
   logic        pc_hold;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fault;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   inst_fetch #(.TIMEOUT_CYCLES(4), .NOP_WORD(NOP)) dut (
      .clock(clock), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid), .flush(flush),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .id_ready(id_ready), .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
      .fetch_fault(fetch_fault), .pc_hold(pc_hold)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Issue an aligned fetch; k = WAIT cycles including the ack cycle. Ends in VALID.
   task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int k);
      exp_q.push_back(exp_t'{data, addr, 1'b0});
      pc_valid = 1'b1;
      pc_in    = addr;
      tick();
      pc_valid = 1'b0;
      check("req_on_accept", {31'b0, imem_req}, 32'd1);
      check("imem_addr", imem_addr, addr);
      check("hold_in_wait", {31'b0, pc_hold}, 32'd1);
      repeat (k - 1) tick();
      check("req_held", {31'b0, imem_req}, 32'd1);
      imem_ack   = 1'b1;
      imem_rdata = data;
      tick();
      imem_ack = 1'b0;
      check("valid_after_ack", {31'b0, instr_valid}, 32'd1);
   endtask

   // Monitor: every accepted instruction must match the head of the scoreboard.
   always @(negedge clock) begin
      if (!reset && instr_valid && id_ready && !flush) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_instr: got %h at pc %h, want none", instr_out, instr_pc);
         end else begin
            mon_e = exp_q.pop_front();
            $display("[TB] retire pc=%h instr=%h fault=%0d", instr_pc, instr_out, fetch_fault);
            check("instr_out", instr_out, mon_e.instr);
            check("instr_pc", instr_pc, mon_e.pc);
            check("fetch_fault", {31'b0, fetch_fault}, {31'b0, mon_e.fault});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset values
      @(posedge clock);
      @(posedge clock);
      #1;
      check("rst_req", {31'b0, imem_req}, 32'd0);
      check("rst_addr", imem_addr, 32'd0);
      check("rst_valid", {31'b0, instr_valid}, 32'd0);
      check("rst_instr", instr_out, NOP);
      check("rst_pc", instr_pc, 32'd0);
      check("rst_fault", {31'b0, fetch_fault}, 32'd0);
      check("rst_hold", {31'b0, pc_hold}, 32'd0);
      reset = 1'b0;
      tick();

      // Basic fetch, ack two cycles after request
      id_ready = 1'b1;
      fetch(32'h0, 32'h2008_0005, 2);
      #1;
      check("hold_valid_ready", {31'b0, pc_hold}, 32'd0);
      tick();
      check("idle_after_accept", {31'b0, instr_valid}, 32'd0);

      // Zero-wait stream with back-to-back restarts
      fetch(32'h0, 32'hA000_0000, 1);
      fetch(32'h4, 32'hA000_0001, 1);
      fetch(32'h8, 32'hA000_0002, 1);
      tick();

      // Decode stall: output held, new pc_valid ignored
      id_ready = 1'b0;
      fetch(32'hC, 32'h1111_0001, 1);
      for (int i = 0; i < 3; i++) begin
         pc_valid = 1'b1;
         pc_in    = 32'h100;
         #1;
         check("stall_hold", {31'b0, pc_hold}, 32'd1);
         check("stall_instr", instr_out, 32'h1111_0001);
         tick();
         check("stall_no_req", {31'b0, imem_req}, 32'd0);
         check("stall_valid", {31'b0, instr_valid}, 32'd1);
      end
      id_ready = 1'b1;
      fetch(32'h10, 32'h2222_0002, 1);
      pc_valid = 1'b0;
      tick();

      // Flush in WAIT, ack two cycles later
      pc_valid = 1'b1;
      pc_in    = 32'h20;
      tick();
      pc_valid = 1'b0;
      flush    = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_req_held0", {31'b0, imem_req}, 32'd1);
      tick();
      check("flush_req_held1", {31'b0, imem_req}, 32'd1);
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_ack = 1'b0;
      check("flush_drop_valid", {31'b0, instr_valid}, 32'd0);
      check("flush_idle_req", {31'b0, imem_req}, 32'd0);
      check("flush_idle_hold", {31'b0, pc_hold}, 32'd0);

      // Flush together with ack
      pc_valid = 1'b1;
      pc_in    = 32'h28;
      tick();
      pc_valid   = 1'b0;
      flush      = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      tick();
      flush    = 1'b0;
      imem_ack = 1'b0;
      check("flushack_valid", {31'b0, instr_valid}, 32'd0);
      check("flushack_req", {31'b0, imem_req}, 32'd0);

      // Flush in VALID overrides id_ready
      id_ready = 1'b0;
      pc_valid = 1'b1;
      pc_in    = 32'h2C;
      tick();
      pc_valid   = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'h4444_0004;
      tick();
      imem_ack = 1'b0;
      check("pre_flush_valid", {31'b0, instr_valid}, 32'd1);
      check("pre_flush_instr", instr_out, 32'h4444_0004);
      flush    = 1'b1;
      id_ready = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_valid_drop", {31'b0, instr_valid}, 32'd0);

      // Flush in IDLE suppresses pc_valid; stray ack in IDLE ignored
      pc_valid = 1'b1;
      flush    = 1'b1;
      pc_in    = 32'h30;
      tick();
      pc_valid = 1'b0;
      flush    = 1'b0;
      check("idle_flush_req", {31'b0, imem_req}, 32'd0);
      imem_ack   = 1'b1;
      imem_rdata = 32'h7777_7777;
      tick();
      imem_ack = 1'b0;
      check("stray_ack_valid", {31'b0, instr_valid}, 32'd0);

      // Misaligned PC, then aligned and misaligned back-to-back restarts
      id_ready = 1'b0;
      exp_q.push_back(exp_t'{NOP, 32'h6, 1'b1});
      pc_valid = 1'b1;
      pc_in    = 32'h6;
      tick();
      pc_valid = 1'b0;
      check("mis_no_req", {31'b0, imem_req}, 32'd0);
      check("mis_valid", {31'b0, instr_valid}, 32'd1);
      check("mis_fault", {31'b0, fetch_fault}, 32'd1);
      check("mis_pc", instr_pc, 32'h6);
      check("mis_instr", instr_out, NOP);
      id_ready = 1'b1;
      fetch(32'h24, 32'h3333_0003, 1);
      exp_q.push_back(exp_t'{NOP, 32'h2A, 1'b1});
      pc_valid = 1'b1;
      pc_in    = 32'h2A;
      tick();
      pc_valid = 1'b0;
      check("mis_b2b_no_req", {31'b0, imem_req}, 32'd0);
      check("mis_b2b_valid", {31'b0, instr_valid}, 32'd1);
      tick();

      // Asynchronous reset mid-WAIT
      pc_valid = 1'b1;
      pc_in    = 32'h50;
      tick();
      pc_valid = 1'b0;
      tick();
      #2;
      reset = 1'b1;
      #1;
      check("arst_req", {31'b0, imem_req}, 32'd0);
      check("arst_addr", imem_addr, 32'd0);
      check("arst_pc", instr_pc, 32'd0);
      check("arst_hold", {31'b0, pc_hold}, 32'd0);
      check("arst_fault", {31'b0, fetch_fault}, 32'd0);
      check("arst_instr", instr_out, NOP);
      tick();
      reset      = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'h5555_5555;
      tick();
      imem_ack = 1'b0;
      check("late_ack_valid", {31'b0, instr_valid}, 32'd0);
      check("late_ack_req", {31'b0, imem_req}, 32'd0);

`ifdef IFETCH_TIMEOUT_EN
      // Timeout after 4 WAIT cycles without ack
      exp_q.push_back(exp_t'{NOP, 32'h40, 1'b1});
      pc_valid = 1'b1;
      pc_in    = 32'h40;
      tick();
      pc_valid = 1'b0;
      repeat (3) tick();
      check("tmo_req_last", {31'b0, imem_req}, 32'd1);
      tick();
      check("tmo_req_drop", {31'b0, imem_req}, 32'd0);
      check("tmo_valid", {31'b0, instr_valid}, 32'd1);
      check("tmo_fault", {31'b0, fetch_fault}, 32'd1);
      check("tmo_instr", instr_out, NOP);
      tick();
      // Timeout of a killed fetch returns to IDLE silently
      pc_valid = 1'b1;
      pc_in    = 32'h44;
      tick();
      pc_valid = 1'b0;
      flush    = 1'b1;
      tick();
      flush = 1'b0;
      repeat (2) tick();
      check("tmo_kill_req_last", {31'b0, imem_req}, 32'd1);
      tick();
      check("tmo_kill_req", {31'b0, imem_req}, 32'd0);
      check("tmo_kill_valid", {31'b0, instr_valid}, 32'd0);
`else
      // Without the timeout feature the request waits indefinitely
      fetch(32'h60, 32'h6666_0006, 21);
      tick();
`endif

      tick();
      check("queue_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage sitting directly downstream of the program counter and upstream of the decoder. Takes the current PC, issues a single-beat read to instruction memory over a req/ack handshake, and holds the returned word in an output register until decode accepts it. Back-pressures the PC with a hold signal and discards in-flight fetches on a taken branch/jump flush. Flags misaligned PCs and, optionally, memory timeouts.

## Interface
- TIMEOUT_CYCLES, 255: max WAIT cycles before timeout fault (only with IFETCH_TIMEOUT_EN); 1..255
- NOP_WORD, 32'h0000_0000: instruction substituted on any fault or flush-kill
- clock  in  1  rising-edge clock for all state
- reset  in  1  reset, asynchronous, active-high
- pc_in  in  32  PC to fetch from
- pc_valid  in  1  pc_in is a new fetch target this cycle
- flush  in  1  taken branch/jump; kill current fetch
- imem_req  out  1  read request to instruction memory
- imem_addr  out  32  word-aligned read address, stable while imem_req=1
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  instruction word
- id_ready  in  1  decode accepts instr_out this cycle
- instr_valid  out  1  instr_out/instr_pc valid
- instr_out  out  32  fetched instruction
- instr_pc  out  32  address instr_out was fetched from
- fetch_fault  out  1  sticky per-instruction fault flag, valid with instr_valid
- pc_hold  out  1  PC must not advance

## Operation
- FSM states: IDLE, WAIT, VALID.
- IDLE: on pc_valid & ~flush, latch pc_in into addr_q. If pc_in[1:0]!=0: skip memory, load instr_out=NOP_WORD, fetch_fault=1, go VALID. Else imem_req=1, go WAIT.
- WAIT: imem_req=1, imem_addr=addr_q held stable. On imem_ack: if kill_q clear, instr_out<=imem_rdata, fetch_fault<=0, go VALID; if kill_q set, drop data, clear kill_q, go IDLE.
- flush in WAIT without ack same cycle: set kill_q; remain WAIT until ack (request must not be withdrawn). flush with ack in same cycle: data dropped, go IDLE.
- VALID: instr_valid=1. On id_ready: go IDLE, or if pc_valid & ~flush same cycle, start the next fetch directly (back-to-back, state WAIT or VALID-with-fault). flush in VALID: instr_valid deasserts next cycle, go IDLE, id_ready ignored.
- instr_pc = addr_q.
- pc_hold = 1 in WAIT, and in VALID while ~id_ready; 0 otherwise.
- pc_valid while pc_hold=1 is ignored.
- flush in IDLE: no effect beyond suppressing a same-cycle pc_valid.

## Timing
- Reset values: state IDLE, imem_req 0, imem_addr 0, instr_valid 0, instr_out NOP_WORD, instr_pc 0, fetch_fault 0, pc_hold 0, kill_q 0, timeout counter 0.
- Reset mid-WAIT: request dropped immediately (asynchronous); a later imem_ack is ignored in IDLE.
- Latency: pc_valid at edge N → imem_req from N; ack at edge N+k → instr_valid from N+k. Zero-wait memory (ack on first WAIT cycle) gives 1 instruction per 2 cycles; back-to-back restart from VALID gives 1 per (1+k).
- Misaligned PC: instr_valid one cycle after acceptance, no memory access.
- imem_ack outside WAIT ignored.

## Configuration
- IFETCH_TIMEOUT_EN defined: 8-bit counter cleared on WAIT entry, increments per WAIT cycle without ack; on reaching TIMEOUT_CYCLES, abandon request (imem_req drops), load NOP_WORD, fetch_fault=1, go VALID (or IDLE if kill_q set).
- Undefined: no counter; WAIT waits indefinitely for imem_ack.

## Test plan
- Reset, pc_valid with pc_in=0x0000_0000, ack after 2 cycles with rdata=0x2008_0005 → instr_valid=1, instr_out=0x2008_0005, instr_pc=0, fetch_fault=0, pc_hold high during WAIT.
- Stream 0x0,0x4,0x8 with zero-wait ack, id_ready=1 → three instructions in order, back-to-back restarts, no dropped or duplicated words.
- id_ready=0 for 3 cycles in VALID → instr_out stable, pc_hold=1, new pc_valid ignored; release → next fetch starts same cycle.
- flush in WAIT, ack 2 cycles later with 0xDEAD_BEEF → imem_req held until ack, word discarded, instr_valid never asserts, state IDLE.
- pc_in=0x0000_0006 → no imem_req, instr_out=0x0000_0000, fetch_fault=1, instr_pc=0x6.
- IFETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → imem_req drops after 4 WAIT cycles, fetch_fault=1, instr_out=NOP_WORD; reset asserted mid-WAIT → all outputs at reset values immediately.
